spi_arbiter_master: RTL and testbench

- SPI master with a built-in arbiter that shares one SPI bus (SCLK/MOSI/MISO) between NUM_REQ on-chip requesters.
- Each requester owns a dedicated active-low slave select.
- Each transaction is one full-duplex word of DATA_W bits, SPI mode 0, MSB first.
- Sits between user logic and the board SPI pins, in the same 50 MHz domain as the SPI wrapper.

---
 rtl/spi_arb_pkg.sv | 15 +
 rtl/spi_shift_engine.sv | 98 +++++++++
 rtl/spi_arbiter_master.sv | 163 ++++++++++++++++
 tb/tb_spi_arbiter_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared constants for the arbitrated SPI master: FSM state encoding and SPI mode.
package spi_arb_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Mode 0: SCLK idles low, data captured on the leading (rising) edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;
    localparam logic SAMPLE_ON_LEAD = ~SPI_CPHA;

endpackage

// File: rtl/spi_shift_engine.sv
// SCLK divider plus TX/RX shift registers for one DATA_W-bit SPI word.
// load latches the TX word; start launches the first SCLK edge; done marks the last shift cycle.
module spi_shift_engine
    import spi_arb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] tx_word,
    input  logic              start,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              done,
    output logic [DATA_W-1:0] rx_word
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(DATA_W);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              active_q, active_d;
    logic              sclk_q, sclk_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              half_end;

    always_comb begin
        div_d    = div_q;
        bit_d    = bit_q;
        active_d = active_q;
        sclk_d   = sclk_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        half_end = active_q && (div_q == DIV_LAST);
        // bit_q counts completed SCLK pulses; the word ends after the last low half-period.
        done     = half_end && !sclk_q && (bit_q == BIT_ALL);

        if (load) begin
            tx_d = tx_word;
            rx_d = '0;
        end

        if (start) begin
            active_d = 1'b1;
            sclk_d   = ~SPI_CPOL;
            div_d    = '0;
            bit_d    = '0;
            if (SAMPLE_ON_LEAD) rx_d = {rx_q[DATA_W-2:0], miso};
        end else if (active_q) begin
            if (!half_end) begin
                div_d = div_q + 1'b1;
            end else begin
                div_d = '0;
                if (sclk_q != SPI_CPOL) begin
                    sclk_d = SPI_CPOL;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q != BIT_LAST) tx_d = {tx_q[DATA_W-2:0], 1'b0};
                end else if (done) begin
                    active_d = 1'b0;
                end else begin
                    sclk_d = ~SPI_CPOL;
                    if (SAMPLE_ON_LEAD) rx_d = {rx_q[DATA_W-2:0], miso};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
            sclk_q   <= SPI_CPOL;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            div_q    <= div_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            sclk_q   <= sclk_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = tx_q[DATA_W-1];
    assign rx_word = rx_q;

endmodule

// File: rtl/spi_arbiter_master.sv
// SPI mode-0 master shared by NUM_REQ requesters, each with its own SS_n line.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module spi_arbiter_master
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic                      clk_50mhz,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    input  logic                      MISO,
    output logic                      MOSI,
    output logic                      SCLK,
    output logic [NUM_REQ-1:0]        SS_n
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ss_n_q, ss_n_d;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic               eng_load, eng_start, eng_done, eng_sclk, eng_mosi;
    logic [DATA_W-1:0]  eng_rx, tx_pick;
    logic               sel_active_d;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Walk downward so the requester closest to the pointer is written last and wins.
    always_comb begin
        int idx;
        winner  = '0;
        any_req = |req_valid;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) winner = IDX_W'(idx);
        end
        ptr_d = ptr_q;
        if (state_q == ST_IDLE && any_req) ptr_d = (winner == IDX_LAST) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        winner  = '0;
        any_req = |req_valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) winner = IDX_W'(i);
        end
    end
`endif

    assign tx_pick = req_data[winner*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        eng_load  = 1'b0;
        eng_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    eng_load = 1'b1;
                    owner_d  = winner;
                    cnt_d    = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_LAST) begin
                    eng_start = 1'b1;
                    state_d   = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (eng_done) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
                else                   cnt_d = cnt_q + 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Slave selects come straight from a flop so the board pins never glitch.
        sel_active_d = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
        ss_n_d = '1;
        if (sel_active_d) ss_n_d[owner_d] = 1'b0;
    end

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            ss_n_q  <= '1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ss_n_q  <= ss_n_d;
        end
    end

    spi_shift_engine #(
        .DATA_W (DATA_W),
        .CLK_DIV(CLK_DIV)
    ) u_engine (
        .clk    (clk_50mhz),
        .rst_n  (reset),
        .load   (eng_load),
        .tx_word(tx_pick),
        .start  (eng_start),
        .miso   (MISO),
        .sclk   (eng_sclk),
        .mosi   (eng_mosi),
        .done   (eng_done),
        .rx_word(eng_rx)
    );

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        MOSI      = 1'b0;
        if (reset && state_q == ST_IDLE && any_req) req_ready[winner] = 1'b1;
        if (state_q == ST_DONE) begin
            rsp_valid[owner_q] = 1'b1;
            rsp_data           = eng_rx;
        end
        if (state_q == ST_SETUP || state_q == ST_SHIFT || state_q == ST_HOLD) MOSI = eng_mosi;
    end

    assign busy = (state_q != ST_IDLE);
    assign SCLK = eng_sclk;
    assign SS_n = ss_n_q;

endmodule

// File: tb/tb_spi_arbiter_master.sv
// Directed bench for spi_arbiter_master: a CLK_DIV=2 instance with a mode-0 slave model
// and a CLK_DIV=1 instance for the fast-divider case.
module tb_spi_arbiter_master;

    localparam int NR = 2;
    localparam int DW = 8;

    logic clk_50mhz = 1'b0;
    logic reset;
    always #10 clk_50mhz = ~clk_50mhz;

    logic [NR-1:0]    req_valid, req_ready, rsp_valid, ss_n;
    logic [NR*DW-1:0] req_data;
    logic [DW-1:0]    rsp_data;
    logic             busy, mosi, sclk;
    logic             miso = 1'b0;

    logic [NR-1:0]    req_valid_1, req_ready_1, rsp_valid_1, ss_n_1;
    logic [NR*DW-1:0] req_data_1;
    logic [DW-1:0]    rsp_data_1;
    logic             busy_1, mosi_1, sclk_1, miso_1;

    spi_arbiter_master #(.NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(2)) dut (
        .clk_50mhz(clk_50mhz), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .MISO(miso), .MOSI(mosi), .SCLK(sclk), .SS_n(ss_n)
    );

    spi_arbiter_master #(.NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(1)) dut1 (
        .clk_50mhz(clk_50mhz), .reset(reset), .req_valid(req_valid_1), .req_data(req_data_1),
        .req_ready(req_ready_1), .rsp_valid(rsp_valid_1), .rsp_data(rsp_data_1), .busy(busy_1),
        .MISO(miso_1), .MOSI(mosi_1), .SCLK(sclk_1), .SS_n(ss_n_1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Mode-0 slave for the CLK_DIV=2 instance, observed on the falling clk edge.
    logic [DW-1:0] slave_tx;
    logic [DW-1:0] slave_sr    = '0;
    logic [DW-1:0] slave_rx    = '0;
    int            sclk_rises  = 0;
    int            ss_err      = 0;
    logic          sclk_prev   = 1'b0;
    logic [NR-1:0] ss_prev     = '1;
    logic          ss_chk_en;
    logic [NR-1:0] ss_expect;

    always @(negedge clk_50mhz) begin
        sclk_prev <= sclk;
        ss_prev   <= ss_n;
        if ((&ss_prev) && !(&ss_n)) begin
            miso       <= slave_tx[DW-1];
            slave_sr   <= {slave_tx[DW-2:0], 1'b0};
            slave_rx   <= '0;
            sclk_rises <= 0;
        end else if (sclk && !sclk_prev) begin
            slave_rx   <= {slave_rx[DW-2:0], mosi};
            sclk_rises <= sclk_rises + 1;
            if (ss_chk_en && ss_n != ss_expect) ss_err <= ss_err + 1;
        end else if (!sclk && sclk_prev) begin
            miso     <= slave_sr[DW-1];
            slave_sr <= {slave_sr[DW-2:0], 1'b0};
        end
    end

    logic          sclk1_prev = 1'b0;
    logic [NR-1:0] ss1_prev   = '1;
    logic [DW-1:0] rx1        = '0;

    always @(negedge clk_50mhz) begin
        sclk1_prev <= sclk_1;
        ss1_prev   <= ss_n_1;
        if ((&ss1_prev) && !(&ss_n_1)) rx1 <= '0;
        else if (sclk_1 && !sclk1_prev) rx1 <= {rx1[DW-2:0], mosi_1};
    end

    // Request on one instance, return at the negedge of the first cycle with rsp_valid set.
    task automatic xfer(input bit on1, input int idx, input logic [DW-1:0] tx, input bit rearm,
                        output int lat, output logic [NR-1:0] rv, output logic [DW-1:0] rd);
        logic [NR-1:0] rdy;
        logic [NR-1:0] one_hot;
        one_hot = '0;
        one_hot[idx] = 1'b1;
        @(negedge clk_50mhz);
        if (on1) begin req_valid_1[idx] = 1'b1; req_data_1[idx*DW +: DW] = tx; end
        else     begin req_valid[idx]   = 1'b1; req_data[idx*DW +: DW]   = tx; end
        #1;
        rdy = on1 ? req_ready_1 : req_ready;
        check_val("accept_ready", rdy, one_hot);
        lat = -1;
        rv  = '0;
        rd  = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk_50mhz);
            if (k == 1) begin
                if (on1) req_valid_1[idx] = 1'b0;
                else     req_valid[idx]   = 1'b0;
            end
            if (k == 2) check_val("busy_in_xfer", on1 ? busy_1 : busy, 1);
            if ((on1 ? rsp_valid_1 : rsp_valid) != '0) begin
                lat = k;
                rv  = on1 ? rsp_valid_1 : rsp_valid;
                rd  = on1 ? rsp_data_1 : rsp_data;
                if (rearm) begin
                    if (on1) req_valid_1[idx] = 1'b1;
                    else     req_valid[idx]   = 1'b1;
                end
                break;
            end
        end
        $display("xfer dut%0d req%0d tx=0x%02h rsp=0x%02h lat=%0d", on1, idx, tx, rd, lat);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_50mhz);
            if (!busy) begin cyc = k; break; end
        end
    endtask

    initial begin
        int lat;
        int cyc;
        int r;
        int g;
        int cnt_a, cnt_b, cnt_c;
        int grant_idx[4];
        int exp_grant[4];
        logic p;
        logic [NR-1:0] rv;
        logic [DW-1:0] rd;

        reset = 1'b0;
        req_valid = '0; req_data = '0;
        req_valid_1 = '0; req_data_1 = '0; miso_1 = 1'b0;
        slave_tx = '0; ss_chk_en = 1'b0; ss_expect = '1;

        // Reset state
        repeat (3) @(negedge clk_50mhz);
        check_val("rst_sclk", sclk, 0);
        check_val("rst_mosi", mosi, 0);
        check_val("rst_ss_n", ss_n, 2'b11);
        check_val("rst_ready", req_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ss_n_div1", ss_n_1, 2'b11);
        reset = 1'b1;
        repeat (2) @(negedge clk_50mhz);

        // Single transfer: req0 sends 0xA5, slave returns 0x3C
        slave_tx = 8'h3C; ss_expect = 2'b10; ss_chk_en = 1'b1;
        xfer(0, 0, 8'hA5, 0, lat, rv, rd);
        ss_chk_en = 1'b0;
        check_val("single_lat", lat, 37);
        check_val("single_rsp_valid", rv, 2'b01);
        check_val("single_rsp_data", rd, 8'h3C);
        check_val("single_mosi_bits", slave_rx, 8'hA5);
        check_val("single_sclk_pulses", sclk_rises, 8);
        check_val("single_ss_n", ss_err, 0);
        check_val("done_ss_n", ss_n, 2'b11);

        // Back-to-back: req0 re-asserted in its DONE cycle
        slave_tx = 8'hC3;
        xfer(0, 0, 8'h81, 1, lat, rv, rd);
        check_val("b2b_first_lat", lat, 37);
        check_val("b2b_done_ss_n", ss_n, 2'b11);
        @(negedge clk_50mhz); #1;
        check_val("b2b_idle_ready", req_ready, 2'b01);
        check_val("b2b_idle_ss_n", ss_n, 2'b11);
        @(negedge clk_50mhz); #1;
        req_valid[0] = 1'b0;
        check_val("b2b_setup_ss_n", ss_n, 2'b10);
        wait_idle(cyc);
        check_val("b2b_idle_reached", cyc >= 0, 1);
        check_val("b2b_second_rx", dut.rsp_data == 8'h00 && slave_rx == 8'h81, 1);

        // Withdrawn request: req1 pulses for one cycle while busy
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        slave_tx = 8'hF0;
        @(negedge clk_50mhz); req_valid[0] = 1'b1; req_data[7:0] = 8'h0F;
        @(negedge clk_50mhz); req_valid[0] = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk_50mhz);
            if (k == 4) req_valid[1] = 1'b1;
            if (k == 5) req_valid[1] = 1'b0;
            #1;
            if (req_ready[1]) cnt_a++;
            if (!ss_n[1]) cnt_b++;
            if (rsp_valid == 2'b01 && rsp_data == 8'hF0) cnt_c++;
        end
        check_val("withdraw_no_ready1", cnt_a, 0);
        check_val("withdraw_no_ss1", cnt_b, 0);
        check_val("withdraw_req0_rsp", cnt_c, 1);

        // Reset after the 3rd rising SCLK edge of a req1 transfer
        slave_tx = 8'h99;
        @(negedge clk_50mhz); req_valid[1] = 1'b1; req_data[15:8] = 8'h77;
        @(negedge clk_50mhz); req_valid[1] = 1'b0;
        r = 0; p = sclk;
        for (int k = 0; k < 200; k++) begin
            if (sclk && !p) r++;
            p = sclk;
            if (r == 3) break;
            @(negedge clk_50mhz);
        end
        check_val("abort_third_edge", r, 3);
        check_val("abort_pre_ss_n", ss_n, 2'b01);
        reset = 1'b0;
        #1;
        check_val("abort_ss_n", ss_n, 2'b11);
        check_val("abort_sclk", sclk, 0);
        check_val("abort_busy", busy, 0);
        cnt_a = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_50mhz);
            if (k == 3) reset = 1'b1;
            #1;
            if (rsp_valid != '0) cnt_a++;
        end
        check_val("abort_no_rsp", cnt_a, 0);
        slave_tx = 8'h5A;
        xfer(0, 1, 8'h5A, 0, lat, rv, rd);
        check_val("echo_lat", lat, 37);
        check_val("echo_rsp_valid", rv, 2'b10);
        check_val("echo_rsp_data", rd, 8'h5A);
        check_val("echo_mosi_bits", slave_rx, 8'h5A);

        // CLK_DIV=1 instance
        miso_1 = 1'b0;
        xfer(1, 0, 8'hFF, 0, lat, rv, rd);
        check_val("div1_lat", lat, 19);
        check_val("div1_rsp_valid", rv, 2'b01);
        check_val("div1_rsp_data", rd, 8'h00);
        check_val("div1_mosi_bits", rx1, 8'hFF);
        miso_1 = 1'b1;
        xfer(1, 1, 8'h00, 0, lat, rv, rd);
        check_val("div1b_lat", lat, 19);
        check_val("div1b_rsp_valid", rv, 2'b10);
        check_val("div1b_rsp_data", rd, 8'hFF);
        check_val("div1b_mosi_bits", rx1, 8'h00);

        // Contention from a fresh reset, both requesters held high
`ifdef SPI_ARB_ROUND_ROBIN_EN
        exp_grant = '{0, 1, 0, 1};
`else
        exp_grant = '{0, 0, 0, 0};
`endif
        @(negedge clk_50mhz); reset = 1'b0;
        @(negedge clk_50mhz); reset = 1'b1;
        slave_tx = 8'h11;
        req_data = {8'h22, 8'h11};
        grant_idx = '{-1, -1, -1, -1};
        g = 0;
        @(negedge clk_50mhz); req_valid = 2'b11;
        for (int k = 0; k < 400 && g < 4; k++) begin
            #1;
            if (req_ready != '0) begin
                grant_idx[g] = req_ready[1] ? 1 : 0;
                g++;
            end
            @(negedge clk_50mhz);
            if (g == 4) req_valid = '0;
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) check_val($sformatf("grant%0d", i), grant_idx[i], exp_grant[i]);
        wait_idle(cyc);
        check_val("contention_idle", cyc >= 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
